spi_slave_shift: RTL and testbench
==================================

Name: spi_slave_shift

Overview:
SPI slave-side serializer/deserializer, the peer of the master shift register. It receives a character on mosi while returning a pre-loaded character on miso, framed by ss_n. The block oversamples sclk, ss_n and mosi in the system clock domain, so no second clock domain exists. It sits between the external SPI pins and the slave register file, which loads tx_data and consumes rx_data.

Parameters:
MAX_CHAR, 32, maximum character length in bits (8/16/24/32).
CHAR_LEN_BITS, 5, width of len; log2(MAX_CHAR).

Ports:
clk  input  1  system clock; must be >= 8x sclk frequency.
rst_n  input  1  asynchronous active-low reset.
len  input  CHAR_LEN_BITS  character length minus one; 0 means MAX_CHAR bits.
lsb  input  1  1 = LSB first on the line.
rx_negedge  input  1  mosi is sampled on the sclk falling edge.
tx_negedge  input  1  miso is updated on the sclk falling edge.
tx_data  input  MAX_CHAR  character to transmit.
tx_load  input  1  write strobe for tx_data.
tx_ready  output  1  tx buffer empty; tx_load is accepted.
rx_data  output  MAX_CHAR  last complete received character, right-aligned.
rx_valid  output  1  one-cycle pulse when rx_data updates.
underrun  output  1  sticky flag: a character started with the tx buffer empty.
underrun_clr  input  1  clears underrun.
busy  output  1  frame active (state ACTIVE).
sclk  input  1  SPI serial clock, asynchronous.
ss_n  input  1  SPI slave select, active low, asynchronous.
mosi  input  1  serial data in.
miso  output  1  serial data out.
miso_oe  output  1  miso output enable; high only while busy.

Behaviour:
- Reset values: tx_ready=1, rx_data=0, rx_valid=0, underrun=0, busy=0, miso=0, miso_oe=0. Reset clears all synchronizers, counters and buffers.
- Synchronization: sclk, ss_n and mosi each pass through a 2-FF synchronizer. Edge flags come from the synced value and its 1-cycle delay. An event at a pin is visible 3 clk later; mosi is delayed identically, so it stays aligned with sclk.
- Tx buffer: tx_load while tx_ready=1 stores tx_data and sets tx_ready=0. tx_load while tx_ready=0 is ignored, and the stored value is unchanged.
- States:
  - IDLE: busy=0, miso_oe=0, miso=0. A synced ss_n falling edge moves to ACTIVE in the same cycle as the char-start actions below.
  - ACTIVE: on a synced ss_n rising edge, return to IDLE. If this aborts a partial character, the partial bits are discarded, rx_valid is not pulsed, and the tx buffer is not restored.
- Char-start actions (ss_n fall, or completion of the previous character while still ACTIVE):
  - Latch len, lsb, rx_negedge and tx_negedge; they are frozen until the frame ends.
  - nbits = (len==0) ? MAX_CHAR : len+1.
  - If tx_ready=0: tx_sh <= buffer and tx_ready <= 1. Otherwise: tx_sh <= 0 and underrun <= 1.
  - k <= 0; miso <= tx_sh bit 0 of the new word.
- Bit index: idx(k) = lsb ? k : nbits-1-k.
- rx edge (synced sclk edge selected by rx_negedge), ACTIVE only: rx_sh[idx(k)] <= mosi_sync; k <= k+1.
- tx edge (the edge selected by tx_negedge), ACTIVE only: miso <= tx_sh[idx(k)], using the current k.
  - This presents the next bit in mode-0 style (tx edge after rx).
  - It re-presents bit 0 when the tx edge precedes the first rx edge (mode-1 style). No extra flag is needed.
- Completion: when an rx edge makes k reach nbits:
  - Next cycle: rx_data <= rx_sh with the final bit merged and bits above nbits-1 zeroed; rx_valid pulses for 1 cycle.
  - Char-start actions fire in the same cycle, supporting back-to-back characters under one ss_n.
- underrun_clr and an underrun set in the same cycle: set wins.
- Simultaneous ss_n rise and completing rx edge: the completion is reported first (rx_valid pulses), then the FSM goes to IDLE.
- Counter k is CHAR_LEN_BITS+1 bits wide and never wraps; it resets to 0 at each char-start.

Decomposition:
- SPI_MAX_CHAR and SPI_CHAR_LEN_BITS come from the shared spi_defines include.
- FSM state encoding (IDLE/ACTIVE) is local to the module.
- One sub-module, spi_sync_edge: 2-FF synchronizer plus delayed copy, with rise/fall outputs and a reset value parameter (1 for ss_n, 0 for sclk/mosi). It is instantiated three times.

Test Plan:
- Mode 0, len=7, lsb=0, tx_data=0xA5, master sends 0x3C -> miso carries 1,0,1,0,0,1,0,1; rx_data=0x0000003C; one rx_valid pulse; underrun=0; tx_ready=1 after ss_n fall.
- Mode 1 (rx_negedge=1, tx_negedge=0), len=0 (32 bits), lsb=1, tx=0x12345678, mosi=0xDEADBEEF -> master receives 0x12345678 LSB-first; rx_data=0xDEADBEEF.
- Two 8-bit characters under one ss_n low, tx loaded 0x11 then 0x22 between them -> two rx_valid pulses; miso returns 0x11 then 0x22.
- No tx_load before ss_n fall -> miso all zeros; underrun=1; underrun_clr pulse -> 0.
- ss_n raised after 5 of 8 bits -> no rx_valid, busy=0 within 4 clk, miso_oe=0; next full frame receives correctly.
- rst_n asserted mid-frame -> all outputs at reset values immediately; tx_ready=1.

Source files
------------

// File: rtl/spi_slave_shift_pkg.sv
// ============================================================================
// spi_slave_shift_pkg : shared SPI character-size constants and mode record
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_slave_shift_pkg;

  localparam int SPI_MAX_CHAR      = 32;
  localparam int SPI_CHAR_LEN_BITS = 5;

  // Line-format options frozen for the duration of a character
  typedef struct packed {
    logic lsb;
    logic rx_negedge;
    logic tx_negedge;
  } spi_mode_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// spi_sync_edge : 2-FF synchronizer with delayed copy and edge flags
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      dly_q  <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~dly_q;
  assign fall_o  = ~sync_q & dly_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_shift.sv
// ============================================================================
// spi_slave_shift : SPI slave serializer/deserializer, oversampled in clk
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_shift
  import spi_slave_shift_pkg::*;
#(
  parameter int MAX_CHAR      = SPI_MAX_CHAR,
  parameter int CHAR_LEN_BITS = SPI_CHAR_LEN_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHAR_LEN_BITS-1:0] len,
  input  logic                     lsb,
  input  logic                     rx_negedge,
  input  logic                     tx_negedge,
  input  logic [MAX_CHAR-1:0]      tx_data,
  input  logic                     tx_load,
  output logic                     tx_ready,
  output logic [MAX_CHAR-1:0]      rx_data,
  output logic                     rx_valid,
  output logic                     underrun,
  input  logic                     underrun_clr,
  output logic                     busy,
  input  logic                     sclk,
  input  logic                     ss_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe
);

  localparam logic [CHAR_LEN_BITS:0] NB_MAX = (CHAR_LEN_BITS+1)'(MAX_CHAR);
  localparam logic [CHAR_LEN_BITS:0] K_ONE  = (CHAR_LEN_BITS+1)'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_ss_lvl,   w_ss_rise,   w_ss_fall;
  logic w_mosi,     w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .level_o(w_sclk_lvl), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .d_i(ss_n),
    .level_o(w_ss_lvl), .rise_o(w_ss_rise), .fall_o(w_ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(mosi),
    .level_o(w_mosi), .rise_o(w_mosi_rise), .fall_o(w_mosi_fall)
  );

  assign w_unused = &{1'b0, w_sclk_lvl, w_mosi_rise, w_mosi_fall};

  state_e                   state_q,    state_d;
  spi_mode_t                mode_q,     mode_d;
  logic [CHAR_LEN_BITS:0]   nbits_q,    nbits_d;
  logic [CHAR_LEN_BITS:0]   k_q,        k_d;
  logic [MAX_CHAR-1:0]      buf_q,      buf_d;
  logic                     tx_ready_q, tx_ready_d;
  logic [MAX_CHAR-1:0]      tx_sh_q,    tx_sh_d;
  logic [MAX_CHAR-1:0]      rx_sh_q,    rx_sh_d;
  logic [MAX_CHAR-1:0]      rx_data_q,  rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     underrun_q, underrun_d;
  logic                     miso_q,     miso_d;

  logic                     w_rx_edge;
  logic                     w_tx_edge;
  logic                     w_char_done;
  logic                     w_last_rx;
  logic                     w_start;
  logic [CHAR_LEN_BITS:0]   w_idx;
  logic [CHAR_LEN_BITS:0]   w_nbits_new;
  logic [CHAR_LEN_BITS:0]   w_first_idx;
  logic [MAX_CHAR-1:0]      w_start_word;
  logic [MAX_CHAR-1:0]      w_mask;

  assign w_rx_edge   = (state_q == ST_ACTIVE) &&
                       (mode_q.rx_negedge ? w_sclk_fall : w_sclk_rise);
  assign w_tx_edge   = (state_q == ST_ACTIVE) &&
                       (mode_q.tx_negedge ? w_sclk_fall : w_sclk_rise);
  assign w_char_done = (state_q == ST_ACTIVE) && (k_q == nbits_q);
  assign w_last_rx   = w_rx_edge && ((k_q + K_ONE) == nbits_q);
  assign w_idx       = mode_q.lsb ? k_q : (nbits_q - K_ONE - k_q);
  // A shift of MAX_CHAR yields zero, so a full-width character keeps every bit
  assign w_mask      = ~({MAX_CHAR{1'b1}} << nbits_q);

  assign w_nbits_new  = (len == '0) ? NB_MAX : ({1'b0, len} + K_ONE);
  assign w_first_idx  = lsb ? '0 : (w_nbits_new - K_ONE);
  assign w_start_word = tx_ready_q ? '0 : buf_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    nbits_d    = nbits_q;
    k_d        = k_q;
    buf_d      = buf_q;
    tx_ready_d = tx_ready_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = underrun_q & ~underrun_clr;
    miso_d     = miso_q;
    w_start    = 1'b0;

    if (tx_load && tx_ready_q) begin
      buf_d      = tx_data;
      tx_ready_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_ss_fall) begin
          state_d = ST_ACTIVE;
          w_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_char_done) begin
          rx_data_d  = rx_sh_q & w_mask;
          rx_valid_d = 1'b1;
          if (w_ss_lvl) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
          end else begin
            w_start = 1'b1;
          end
        // A deselect coinciding with the final rx edge is deferred one cycle
        end else if (w_ss_rise && !w_last_rx) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end else begin
          if (w_tx_edge && (k_q < nbits_q)) begin
            miso_d = tx_sh_q[w_idx[CHAR_LEN_BITS-1:0]];
          end
          if (w_rx_edge) begin
            rx_sh_d[w_idx[CHAR_LEN_BITS-1:0]] = w_mosi;
            k_d = k_q + K_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_start) begin
      mode_d  = '{lsb: lsb, rx_negedge: rx_negedge, tx_negedge: tx_negedge};
      nbits_d = w_nbits_new;
      k_d     = '0;
      tx_sh_d = w_start_word;
      miso_d  = w_start_word[w_first_idx[CHAR_LEN_BITS-1:0]];
      if (tx_ready_q) begin
        underrun_d = 1'b1;
      end else begin
        tx_ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      nbits_q    <= NB_MAX;
      k_q        <= '0;
      buf_q      <= '0;
      tx_ready_q <= 1'b1;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      nbits_q    <= nbits_d;
      k_q        <= k_d;
      buf_q      <= buf_d;
      tx_ready_q <= tx_ready_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      miso_q     <= miso_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  assign busy     = (state_q == ST_ACTIVE);
  assign miso_oe  = (state_q == ST_ACTIVE);
  assign miso     = miso_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_shift.sv
// ============================================================================
// tb_spi_slave_shift : SPI master model driving spi_slave_shift
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_shift;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  len = '0;
  logic        lsb = 1'b0;
  logic        rx_negedge = 1'b0;
  logic        tx_negedge = 1'b1;
  logic [31:0] tx_data = '0;
  logic        tx_load = 1'b0;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        underrun;
  logic        underrun_clr = 1'b0;
  logic        busy;
  logic        sclk = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;
  logic [31:0] rxq[$];

  spi_slave_shift dut (
    .clk(clk), .rst_n(rst_n), .len(len), .lsb(lsb),
    .rx_negedge(rx_negedge), .tx_negedge(tx_negedge),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun),
    .underrun_clr(underrun_clr), .busy(busy), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      vcount = vcount + 1;
      rxq.push_back(rx_data);
    end
  end

  typedef struct {
    logic        rxneg;
    logic        lsbf;
    logic [4:0]  len;
    logic        load;
    logic [31:0] tx;
    logic [31:0] mo;
    logic [31:0] exp_miso;
    logic [31:0] exp_rx;
    logic        exp_unr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int nbits_of(input logic [4:0] l);
    return (l == 5'd0) ? 32 : int'(l) + 1;
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Line position i carries word bit (lsb ? i : n-1-i)
  function automatic logic [63:0] to_line(input logic [31:0] w, input int n, input logic lf);
    logic [63:0] l;
    l = '0;
    for (int i = 0; i < n; i++) l[i] = w[lf ? i : n - 1 - i];
    return l;
  endfunction

  function automatic logic [31:0] from_line(input logic [63:0] l, input int n, input logic lf);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[lf ? i : n - 1 - i] = l[i];
    return w;
  endfunction

  task automatic load_tx(input logic [31:0] d);
    int t;
    t = 0;
    while (!tx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) chk("tx_ready_wait_timeout", 64'd0, 64'd1);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic clr_underrun();
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    @(negedge clk);
  endtask

  // Master side: mode 0 samples miso before the rising edge, mode 1 before the falling edge
  task automatic clock_bits(input logic rxn, input int n, input logic [63:0] mo,
                            output logic [63:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      if (!rxn) begin
        mosi = mo[i];
        wait_clk(HALF);
        mi[i] = miso;
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        mosi = mo[i];
        wait_clk(HALF);
        mi[i] = miso;
        sclk = 1'b0;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [63:0] mi;
    int n, vbase;
    n = nbits_of(v.len);
    rx_negedge = v.rxneg;
    tx_negedge = ~v.rxneg;
    lsb = v.lsbf;
    len = v.len;
    vbase = vcount;
    rxq.delete();
    if (v.load) load_tx(v.tx);
    ss_n = 1'b0;
    wait_clk(HALF);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    chk({tag, "_underrun"}, {63'd0, underrun}, {63'd0, v.exp_unr});
    chk({tag, "_tx_ready"}, {63'd0, tx_ready}, 64'd1);
    clock_bits(v.rxneg, n, to_line(v.mo, n, v.lsbf), mi);
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(HALF);
    chk({tag, "_miso_word"}, {32'd0, from_line(mi, n, v.lsbf)}, {32'd0, v.exp_miso});
    chk({tag, "_rx_valid_count"}, 64'(vcount - vbase), 64'd1);
    if (rxq.size() > 0) chk({tag, "_rx_data"}, {32'd0, rxq[0]}, {32'd0, v.exp_rx});
    else chk({tag, "_rx_data_missing"}, 64'd0, 64'd1);
    chk({tag, "_idle"}, {62'd0, busy, miso_oe}, 64'd0);
    clr_underrun();
  endtask

  initial begin
    logic [63:0] mi;
    vec_t r;
    int vbase;

    vecs[0] = '{1'b0, 1'b0, 5'd7,  1'b1, 32'hA5,       32'h3C,       32'hA5,       32'h3C,       1'b0};
    vecs[1] = '{1'b1, 1'b1, 5'd0,  1'b1, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 5'd7,  1'b1, 32'hC3,       32'h5A,       32'hC3,       32'h5A,       1'b0};
    vecs[3] = '{1'b0, 1'b0, 5'd7,  1'b0, 32'hFF,       32'h81,       32'h00,       32'h81,       1'b1};
    vecs[4] = '{1'b0, 1'b1, 5'd15, 1'b1, 32'hBEEF,     32'h1234,     32'hBEEF,     32'h1234,     1'b0};
    vecs[5] = '{1'b1, 1'b0, 5'd23, 1'b1, 32'hABCDEF,   32'h987654,   32'hABCDEF,   32'h987654,   1'b0};

    wait_clk(3);
    chk("reset_outputs", {32'd0, rx_data}, 64'd0);
    chk("reset_flags", {58'd0, tx_ready, rx_valid, underrun, busy, miso, miso_oe}, 64'b100000);
    rst_n = 1'b1;
    wait_clk(3);
    chk("post_reset_flags", {58'd0, tx_ready, rx_valid, underrun, busy, miso, miso_oe}, 64'b100000);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      if (vecs[i].exp_unr) chk($sformatf("vec%0d_underrun_clr", i), {63'd0, underrun}, 64'd0);
    end

    // Ignored second load while buffer full
    load_tx(32'h5C);
    tx_data = 32'hE7;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    r = '{1'b0, 1'b0, 5'd7, 1'b0, 32'h0, 32'hC6, 32'h5C, 32'hC6, 1'b0};
    run_frame(r, "ignored_load");

    // Two characters under one ss_n low
    rx_negedge = 1'b0; tx_negedge = 1'b1; lsb = 1'b0; len = 5'd7;
    rxq.delete();
    vbase = vcount;
    load_tx(32'h11);
    ss_n = 1'b0;
    wait_clk(HALF);
    load_tx(32'h22);
    clock_bits(1'b0, 16, to_line({16'd0, 8'hA1, 8'h5B}, 16, 1'b0), mi);
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(HALF);
    chk("b2b_miso_word", {48'd0, from_line(mi, 16, 1'b0)}, 64'h1122);
    chk("b2b_rx_valid_count", 64'(vcount - vbase), 64'd2);
    if (rxq.size() == 2) begin
      chk("b2b_rx_first", {32'd0, rxq[0]}, 64'hA1);
      chk("b2b_rx_second", {32'd0, rxq[1]}, 64'h5B);
    end else chk("b2b_rx_queue_size", 64'(rxq.size()), 64'd2);
    clr_underrun();

    // Abort after 5 of 8 bits
    vbase = vcount;
    load_tx(32'h96);
    ss_n = 1'b0;
    wait_clk(HALF);
    clock_bits(1'b0, 5, 64'h1F, mi);
    chk("abort_busy_mid", {62'd0, busy, miso_oe}, 64'b11);
    ss_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle_4clk", {61'd0, busy, miso_oe, miso}, 64'd0);
    wait_clk(HALF);
    chk("abort_no_rx_valid", 64'(vcount - vbase), 64'd0);
    chk("abort_tx_ready", {63'd0, tx_ready}, 64'd1);
    r = '{1'b0, 1'b0, 5'd7, 1'b1, 32'h69, 32'hB4, 32'h69, 32'hB4, 1'b0};
    run_frame(r, "after_abort");

    // Randomized frames against the line-level model
    for (int i = 0; i < 16; i++) begin
      r.rxneg = 1'($urandom_range(0, 1));
      r.lsbf  = 1'($urandom_range(0, 1));
      r.len   = 5'($urandom_range(0, 31));
      r.load  = ($urandom_range(0, 4) != 0);
      r.tx    = $urandom;
      r.mo    = $urandom;
      r.exp_miso = r.load ? (r.tx & mask_of(nbits_of(r.len))) : 32'd0;
      r.exp_rx   = r.mo & mask_of(nbits_of(r.len));
      r.exp_unr  = ~r.load;
      run_frame(r, $sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-frame
    load_tx(32'hF0);
    ss_n = 1'b0;
    wait_clk(HALF);
    clock_bits(1'b0, 3, 64'h5, mi);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rx_data", {32'd0, rx_data}, 64'd0);
    chk("midreset_flags", {58'd0, tx_ready, rx_valid, underrun, busy, miso, miso_oe}, 64'b100000);
    ss_n = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    chk("after_reset_flags", {58'd0, tx_ready, rx_valid, underrun, busy, miso, miso_oe}, 64'b100000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
